// File: rtl/eth_framing_pkg.sv
// Shared types for the Ethernet TX framer: FSM states, AXIS beat structs and
// the source-MAC byte selector.
package eth_framing_pkg;

  localparam int unsigned MacBytes = 6;

  typedef enum logic [1:0] {DEST, SRC, PAYLOAD, PAD} tx_state_e;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
    logic [0:0] user;
  } axis_beat_t;

  typedef struct packed {
    logic       tvalid;
    axis_beat_t t;
  } axis_req_t;

  typedef struct packed {
    logic tready;
  } axis_rsp_t;

  // Byte idx of a MAC address, byte 0 being bits [47:40] (sent first).
  function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [5:0] idx);
    logic [47:0] sh;
    sh = mac << (8 * int'(idx));
    return sh[47:40];
  endfunction

endpackage

// File: rtl/eth_tx_framer.sv
// Inserts the source MAC after the destination MAC of an upstream frame and
// zero-pads short frames to MinFrameLen bytes (FCS excluded).
module eth_tx_framer
  import eth_framing_pkg::*;
#(
  parameter type axi_stream_req_t = eth_framing_pkg::axis_req_t,
  parameter type axi_stream_rsp_t = eth_framing_pkg::axis_rsp_t,
  parameter int unsigned MinFrameLen = 60
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  axi_stream_req_t tx_axis_req_i,
  output axi_stream_rsp_t tx_axis_rsp_o,
  output axi_stream_req_t mac_axis_req_o,
  input  axi_stream_rsp_t mac_axis_rsp_i,
  input  logic [47:0]     mac_address_i,
  input  logic            pad_en_i,
  output logic [31:0]     tx_frames_o
);

  localparam logic [5:0] LastDestCnt = 6'(MacBytes - 1);
  localparam logic [5:0] LastSrcCnt  = 6'(2 * MacBytes - 1);
  localparam logic [5:0] LastPadCnt  = 6'(MinFrameLen - 1);
  localparam logic [6:0] MinLen7     = 7'(MinFrameLen);

  tx_state_e       state_q, state_d;
  logic [5:0]      cnt_q, cnt_d;
  logic [47:0]     mac_q, mac_d;
  logic            user_q, user_d;
  logic [31:0]     frames_q, frames_d;
  axi_stream_req_t out_req;
  axi_stream_rsp_t in_rsp;
  logic            in_hs, out_hs;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= DEST;
      cnt_q    <= '0;
      mac_q    <= '0;
      user_q   <= 1'b0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mac_q    <= mac_d;
      user_q   <= user_d;
      frames_q <= frames_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    mac_d         = mac_q;
    user_d        = user_q;
    out_req       = '0;
    in_rsp        = '0;
    in_hs         = tx_axis_req_i.tvalid & mac_axis_rsp_i.tready;
    out_hs        = 1'b0;

    unique case (state_q)
      DEST: begin
        out_req.tvalid = tx_axis_req_i.tvalid;
        out_req.t      = tx_axis_req_i.t;
        in_rsp.tready  = mac_axis_rsp_i.tready;
        // A last inside the destination MAC is a runt: flag it as errored.
        if (tx_axis_req_i.t.last) out_req.t.user = 1'b1;
        if (in_hs) begin
          if (cnt_q == '0) mac_d = mac_address_i;
          if (tx_axis_req_i.t.last) begin
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 6'd1;
            if (cnt_q == LastDestCnt) state_d = SRC;
          end
        end
      end
      SRC: begin
        out_req.tvalid = 1'b1;
        out_req.t.data = mac_byte(mac_q, cnt_q - 6'(MacBytes));
        if (mac_axis_rsp_i.tready) begin
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == LastSrcCnt) state_d = PAYLOAD;
        end
      end
      PAYLOAD: begin
        out_req.tvalid = tx_axis_req_i.tvalid;
        out_req.t      = tx_axis_req_i.t;
        in_rsp.tready  = mac_axis_rsp_i.tready;
        // Short frame with padding: hold back last, padding finishes the frame.
        if (tx_axis_req_i.t.last && pad_en_i && ({1'b0, cnt_q} + 7'd1 < MinLen7)) begin
          out_req.t.last = 1'b0;
          out_req.t.user = 1'b0;
          if (in_hs) begin
            user_d  = tx_axis_req_i.t.user[0];
            cnt_d   = cnt_q + 6'd1;
            state_d = PAD;
          end
        end else if (in_hs) begin
          if (tx_axis_req_i.t.last) begin
            cnt_d   = '0;
            state_d = DEST;
          end else if (cnt_q != 6'd63) begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      PAD: begin
        out_req.tvalid = 1'b1;
        if (cnt_q == LastPadCnt) begin
          out_req.t.last = 1'b1;
          out_req.t.user = user_q;
        end
        if (mac_axis_rsp_i.tready) begin
          if (cnt_q == LastPadCnt) begin
            cnt_d   = '0;
            state_d = DEST;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      default: begin
        state_d = DEST;
        cnt_d   = '0;
      end
    endcase

    out_hs   = out_req.tvalid & mac_axis_rsp_i.tready;
    frames_d = (out_hs && out_req.t.last) ? frames_q + 32'd1 : frames_q;
  end

  assign mac_axis_req_o = out_req;
  assign tx_axis_rsp_o  = in_rsp;
  assign tx_frames_o    = frames_q;

endmodule

// File: tb/tb_eth_tx_framer.sv
// Directed bench for eth_tx_framer: padding, no padding, long frame,
// backpressure with input gaps, runt abort and mid-frame reset.
module tb_eth_tx_framer;
  import eth_framing_pkg::*;

  logic        clk_i = 1'b0;
  logic        rst_i;
  axis_req_t   in_req, mac_req;
  axis_rsp_t   in_rsp, mac_rsp;
  logic [47:0] mac_addr;
  logic        pad_en;
  logic [31:0] tx_frames;

  always #5 clk_i = ~clk_i;

  eth_tx_framer #(
    .axi_stream_req_t(axis_req_t),
    .axi_stream_rsp_t(axis_rsp_t),
    .MinFrameLen(60)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .tx_axis_req_i (in_req),
    .tx_axis_rsp_o (in_rsp),
    .mac_axis_req_o(mac_req),
    .mac_axis_rsp_i(mac_rsp),
    .mac_address_i (mac_addr),
    .pad_en_i      (pad_en),
    .tx_frames_o   (tx_frames)
  );

  int ncmp = 0;
  int nfail = 0;

  logic [7:0] in_q[$];
  logic       in_user;
  logic [7:0] exp_q[$];
  logic [7:0] od[$];
  logic       ol[$];
  logic       ou[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Dest FF*6, EtherType 0x0800, then plen payload bytes 0x11, 0x12, ...
  task automatic mk_frame(input int plen, input logic u);
    in_q.delete();
    for (int i = 0; i < 6; i++) in_q.push_back(8'hFF);
    in_q.push_back(8'h08);
    in_q.push_back(8'h00);
    for (int i = 0; i < plen; i++) in_q.push_back(8'(8'h11 + i));
    in_user = u;
  endtask

  task automatic mk_exp(input bit pad, input logic [47:0] m);
    exp_q.delete();
    for (int i = 0; i < 6; i++) exp_q.push_back(in_q[i]);
    for (int i = 0; i < 6; i++) exp_q.push_back(m[47 - 8*i -: 8]);
    for (int i = 6; i < in_q.size(); i++) exp_q.push_back(in_q[i]);
    if (pad) while (exp_q.size() < 60) exp_q.push_back(8'h00);
  endtask

  // Drives in_q and collects output beats until an output last, or until
  // stop_after beats when nonzero. Entered and left at posedge+1.
  task automatic run(input bit bp, input bit gap, input int stop_after, input bit chg_mac);
    int idx = 0;
    int cyc = 0;
    int stab_bad = 0;
    bit done = 0;
    bit pend = 0;
    bit held = 0;
    bit tgl = 1;
    axis_beat_t hold_t;
    logic [47:0] mac_save;
    mac_save = mac_addr;
    od.delete(); ol.delete(); ou.delete();
    while (!done && cyc < 2000) begin
      mac_rsp.tready = bp ? tgl : 1'b1;
      tgl = ~tgl;
      if (!pend) begin
        if (idx < in_q.size() && !(gap && (cyc % 3 == 1))) begin
          in_req.tvalid = 1'b1;
          in_req.t.data = in_q[idx];
          in_req.t.last = (idx == in_q.size() - 1);
          in_req.t.user = (idx == in_q.size() - 1) ? in_user : 1'b0;
        end else begin
          in_req = '0;
        end
      end
      @(negedge clk_i);
      if (held && (!mac_req.tvalid || mac_req.t !== hold_t)) stab_bad++;
      held   = mac_req.tvalid && !mac_rsp.tready;
      hold_t = mac_req.t;
      if (mac_req.tvalid && mac_rsp.tready) begin
        od.push_back(mac_req.t.data);
        ol.push_back(mac_req.t.last);
        ou.push_back(mac_req.t.user[0]);
        if (mac_req.t.last) done = 1;
        if (stop_after != 0 && od.size() == stop_after) done = 1;
        if (chg_mac && od.size() == 2) mac_addr = ~mac_addr;
      end
      if (in_req.tvalid && in_rsp.tready) idx++;
      pend = in_req.tvalid && !in_rsp.tready;
      @(posedge clk_i); #1;
      cyc++;
    end
    in_req = '0;
    mac_rsp.tready = 1'b1;
    if (chg_mac) mac_addr = mac_save;
    chk("run_done", 64'(done), 64'd1);
    chk("hold_stable", 64'(stab_bad), 64'd0);
  endtask

  task automatic cmp_frame(input string tag, input logic exp_user);
    chk({tag, "_len"}, 64'(od.size()), 64'(exp_q.size()));
    if (od.size() == exp_q.size()) begin
      for (int i = 0; i < od.size(); i++) begin
        chk($sformatf("%s_data%0d", tag, i), 64'(od[i]), 64'(exp_q[i]));
        chk($sformatf("%s_last%0d", tag, i), 64'(ol[i]), 64'(i == od.size() - 1));
        chk($sformatf("%s_user%0d", tag, i), 64'(ou[i]),
            (i == od.size() - 1) ? 64'(exp_user) : 64'd0);
      end
    end
  endtask

  initial begin
    rst_i = 1'b1;
    in_req = '0;
    mac_rsp.tready = 1'b1;
    mac_addr = 48'h02_00_00_AA_BB_CC;
    pad_en = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst_mac_tvalid", 64'(mac_req.tvalid), 64'd0);
    chk("rst_in_tready1", 64'(in_rsp.tready), 64'd1);
    chk("rst_frames", 64'(tx_frames), 64'd0);
    mac_rsp.tready = 1'b0;
    #1;
    chk("rst_in_tready0", 64'(in_rsp.tready), 64'd0);
    mac_rsp.tready = 1'b1;
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    // Short frame, padded to 60
    mk_frame(10, 1'b0);
    mk_exp(1'b1, mac_addr);
    run(0, 0, 0, 0);
    cmp_frame("pad", 1'b0);
    chk("pad_src0", 64'(od[6]), 64'h02);
    chk("pad_src5", 64'(od[11]), 64'hCC);
    chk("pad_b26", 64'(od[26]), 64'h00);
    chk("pad_frames", 64'(tx_frames), 64'd1);

    // Same frame without padding; mac_address_i changes mid-frame
    pad_en = 1'b0;
    mk_exp(1'b0, mac_addr);
    run(0, 0, 0, 1);
    cmp_frame("nopad", 1'b0);
    chk("nopad_frames", 64'(tx_frames), 64'd2);

    // Long frame passes user of the final beat
    pad_en = 1'b1;
    mk_frame(92, 1'b1);
    mk_exp(1'b0, mac_addr);
    run(0, 0, 0, 0);
    cmp_frame("long", 1'b1);
    chk("long_len106", 64'(od.size()), 64'd106);
    chk("long_frames", 64'(tx_frames), 64'd3);

    // Backpressure and input gaps; padded frame carries user into last pad beat
    mk_frame(10, 1'b1);
    mk_exp(1'b1, mac_addr);
    run(1, 1, 0, 0);
    cmp_frame("bp", 1'b1);
    chk("bp_frames", 64'(tx_frames), 64'd4);

    // Runt: last on dest byte 3
    in_q = '{8'h01, 8'h02, 8'h03, 8'h04};
    in_user = 1'b0;
    exp_q = in_q;
    run(0, 0, 0, 0);
    cmp_frame("runt", 1'b1);
    chk("runt_frames", 64'(tx_frames), 64'd5);
    mk_frame(10, 1'b0);
    mk_exp(1'b1, mac_addr);
    run(0, 0, 0, 0);
    cmp_frame("post_runt", 1'b0);
    chk("post_runt_frames", 64'(tx_frames), 64'd6);

    // Reset during SRC at cnt=8, then a frame with a new source MAC
    run(0, 0, 8, 0);
    chk("part_len", 64'(od.size()), 64'd8);
    rst_i = 1'b1;
    #1;
    chk("mid_rst_tvalid", 64'(mac_req.tvalid), 64'd0);
    chk("mid_rst_frames", 64'(tx_frames), 64'd0);
    @(posedge clk_i); #1;
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("post_rst_idle", 64'(mac_req.tvalid), 64'd0);
    mac_addr = 48'h12_34_56_78_9A_BC;
    mk_exp(1'b1, mac_addr);
    run(0, 0, 0, 0);
    cmp_frame("post_rst", 1'b0);
    chk("post_rst_src0", 64'(od[6]), 64'h12);
    chk("post_rst_frames", 64'(tx_frames), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/eth_tx_framer.md
ETH_TX_FRAMER -- requirements
Module: eth_tx_framer

Interface
REQ-001 SHALL have parameter axi_stream_req_t, default logic: AXIS request struct with fields tvalid, t.data (8 bit), t.last, t.user (1 bit).
REQ-002 SHALL have parameter axi_stream_rsp_t, default logic: AXIS response struct with field tready.
REQ-003 SHALL have parameter MinFrameLen, default 60: minimum output frame length in bytes, excluding FCS; legal range 13..63.
REQ-004 SHALL have port clk_i, input, 1: the single clock; all state SHALL be clocked on its rising edge.
REQ-005 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have port tx_axis_req_i, input, axi_stream_req_t: upstream frame carrying destination MAC, then EtherType, then payload.
REQ-007 SHALL have port tx_axis_rsp_o, output, axi_stream_rsp_t: upstream tready.
REQ-008 SHALL have port mac_axis_req_o, output, axi_stream_req_t: framed stream toward the MAC/RGMII TX.
REQ-009 SHALL have port mac_axis_rsp_i, input, axi_stream_rsp_t: MAC tready.
REQ-010 SHALL have port mac_address_i, input, 48: source MAC; bits [47:40] are transmitted first.
REQ-011 SHALL have port pad_en_i, input, 1: enable padding of short frames to MinFrameLen.
REQ-012 SHALL have port tx_frames_o, output, 32: count of completed output frames.

Function
REQ-013 SHALL implement an FSM with states DEST, SRC, PAYLOAD, PAD and a 6-bit byte counter cnt that counts output beats.
REQ-014 In DEST, the block SHALL pass data through combinationally (0 latency): mac tvalid = in tvalid, in tready = mac tready, data/user copied; a handshake increments cnt; the handshake at cnt==5 moves the FSM to SRC.
REQ-015 On the DEST handshake with cnt==0, the block SHALL latch mac_address_i into mac_q; changes to mac_address_i mid-frame SHALL NOT affect the current frame.
REQ-016 In DEST, in t.last SHALL produce an output beat with last=1 and user=1 (runt abort), then the FSM SHALL return to DEST with cnt=0.
REQ-017 In SRC, the block SHALL drive in tready=0, mac tvalid=1, data=mac_q byte (cnt-6) MSB first, last=0, user=0; on the cnt==11 handshake the FSM SHALL move to PAYLOAD.
REQ-018 In PAYLOAD, the block SHALL pass data through as in DEST; cnt SHALL increment per handshake and saturate at 63.
REQ-019 A PAYLOAD input last handshake with pad_en_i=1 and cnt+1 < MinFrameLen SHALL output that byte with last=0, store its user in user_q, and move the FSM to PAD.
REQ-020 Otherwise, a PAYLOAD input last handshake SHALL output last=1 with user passed through, and move the FSM to DEST with cnt=0.
REQ-021 In PAD, the block SHALL drive in tready=0, mac tvalid=1, data=0x00; last=1 and user=user_q SHALL be driven when cnt==MinFrameLen-1, else 0; the handshake of that final beat SHALL move the FSM to DEST with cnt=0.
REQ-022 pad_en_i SHALL be sampled only at the input last handshake.
REQ-023 tx_frames_o SHALL increment, wrapping modulo 2^32, on every output handshake with last=1, including aborts.
REQ-024 The output SHALL hold data/last/user stable while tvalid=1 and tready=0.

Reset
REQ-025 During rst_i=1 and after release: FSM=DEST, cnt=0, mac_q=0, user_q=0, tx_frames_o=0, mac tvalid=0 unless in tvalid=1, tx tready=mac tready.
REQ-026 Reset asserted mid-frame SHALL abandon the frame; no PAD or SRC beats SHALL follow reset release.

Structure
REQ-027 The state enum and the MAC address byte-count constant (6) SHALL live in eth_framing_pkg.
REQ-028 No sub-module is required; the block SHALL be a single FSM plus counters, to be instantiated ahead of rgmii_soc TX.

Verification
REQ-029 Test short frame: mac_address_i=0x02_00_00_AA_BB_CC, input 6B dest FF:FF:FF:FF:FF:FF + 0x0800 + 10B payload, pad_en_i=1 -> 60 bytes output, bytes 6..11 = 02 00 00 AA BB CC, bytes 26..59 = 0x00, last only on byte 59, tx_frames_o=1.
REQ-030 Test no padding: same frame with pad_en_i=0 -> 24 bytes output, last on byte 23.
REQ-031 Test long frame: 100B input -> 106B output, no pad beats, user on the final beat = input user.
REQ-032 Test backpressure: mac tready toggling 1/0 every cycle, plus in tvalid gaps -> output byte sequence identical to REQ-029, no duplicated or dropped beats.
REQ-033 Test runt: input last on dest byte 3 -> output 4 beats, final beat last=1/user=1, next frame framed correctly.
REQ-034 Test reset mid-frame: rst_i pulse during SRC at cnt=8 -> next frame starts in DEST with a fresh mac_q and tx_frames_o=0.
